// File: rtl/isa_pkg.sv
// Shared ISA definitions for the decode stage and the execute-stage ALU:
// opcodes, ALU modes, instruction field positions and the decode FSM states.
package isa_pkg;

    localparam int OPC_HI = 15;
    localparam int OPC_LO = 11;
    localparam int RD_HI  = 10;
    localparam int RD_LO  = 8;
    localparam int RS1_HI = 7;
    localparam int RS1_LO = 5;
    localparam int RS2_HI = 4;
    localparam int RS2_LO = 2;

    localparam logic [4:0] OP_NOP  = 5'b00000;
    localparam logic [4:0] OP_ADD  = 5'b00001;
    localparam logic [4:0] OP_SUB  = 5'b00010;
    localparam logic [4:0] OP_AND  = 5'b00011;
    localparam logic [4:0] OP_OR   = 5'b00100;
    localparam logic [4:0] OP_MOV  = 5'b00101;
    localparam logic [4:0] OP_LDM  = 5'b00110;
    localparam logic [4:0] OP_IADD = 5'b00111;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    typedef enum logic {
        S_DECODE = 1'b0,
        S_IMM    = 1'b1
    } state_t;

endpackage

// File: rtl/reg_file.sv
// Architectural register file: one write port, two combinational read ports
// that forward write-back data written in the same cycle.
module reg_file #(
    parameter int DATA_W = 16,
    parameter int NREGS  = 8,
    parameter int AW     = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_wb_en,
    input  logic [AW-1:0]     i_wb_addr,
    input  logic [DATA_W-1:0] i_wb_data,
    input  logic [AW-1:0]     i_rd_addr1,
    input  logic [AW-1:0]     i_rd_addr2,
    output logic [DATA_W-1:0] o_rd_data1,
    output logic [DATA_W-1:0] o_rd_data2
);

    logic [DATA_W-1:0] r_mem [NREGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) r_mem[i] <= '0;
        end else if (i_wb_en) begin
            r_mem[i_wb_addr] <= i_wb_data;
        end
    end

    always_comb begin
        o_rd_data1 = (i_wb_en && i_wb_addr == i_rd_addr1) ? i_wb_data : r_mem[i_rd_addr1];
        o_rd_data2 = (i_wb_en && i_wb_addr == i_rd_addr2) ? i_wb_data : r_mem[i_rd_addr2];
    end

endmodule

// File: rtl/decode_stage.sv
// Instruction decode: register file read, one/two-word decode FSM and the
// ID/EX pipeline register (enable = !stall, clear = flush).
module decode_stage
    import isa_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int NREGS  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       instr_i,
    input  logic              instr_valid_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              wb_en_i,
    input  logic [2:0]        wb_addr_i,
    input  logic [DATA_W-1:0] wb_data_i,
    output logic [DATA_W-1:0] Op1,
    output logic [DATA_W-1:0] Op2,
    output logic [1:0]        AlUmode,
    output logic [2:0]        rdst_o,
    output logic              wb_en_o,
    output logic              valid_o,
    output logic              imm_wait_o,
    output logic              illegal_o
);

    state_t            r_state, w_state_nxt;
    logic [4:0]        r_hold_opc;
    logic [2:0]        r_hold_rdst, r_hold_rs1;
    logic [DATA_W-1:0] r_op1_p1, r_op2_p1;
    logic [1:0]        r_mode_p1;
    logic [2:0]        r_rdst_p1;
    logic              r_wb_p1, r_vld_p1, r_illegal_p1;

    logic [4:0]        w_opc;
    logic [2:0]        w_rdst, w_rs1, w_rs2, w_rd_addr1;
    logic [DATA_W-1:0] w_rd_data1, w_rd_data2;
    logic [DATA_W-1:0] w_op1, w_op2;
    logic [1:0]        w_mode;
    logic [2:0]        w_rdst_nxt;
    logic              w_wb, w_vld, w_illegal, w_load;

    assign w_opc  = instr_i[OPC_HI:OPC_LO];
    assign w_rdst = instr_i[RD_HI:RD_LO];
    assign w_rs1  = instr_i[RS1_HI:RS1_LO];
    assign w_rs2  = instr_i[RS2_HI:RS2_LO];

    // The immediate word carries no register fields, so rs1 comes from the holding reg.
    assign w_rd_addr1 = (r_state == S_IMM) ? r_hold_rs1 : w_rs1;

    reg_file #(.DATA_W(DATA_W), .NREGS(NREGS)) u_rf (
        .clk        (clk),
        .rst_n      (reset),
        .i_wb_en    (wb_en_i),
        .i_wb_addr  (wb_addr_i),
        .i_wb_data  (wb_data_i),
        .i_rd_addr1 (w_rd_addr1),
        .i_rd_addr2 (w_rs2),
        .o_rd_data1 (w_rd_data1),
        .o_rd_data2 (w_rd_data2)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_op1       = '0;
        w_op2       = '0;
        w_mode      = ALU_ADD;
        w_rdst_nxt  = '0;
        w_wb        = 1'b0;
        w_vld       = 1'b0;
        w_illegal   = 1'b0;
        if (r_state == S_DECODE) begin
            if (instr_valid_i) begin
                case (w_opc)
                    OP_NOP: ;
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_MOV: begin
                        w_vld      = 1'b1;
                        w_wb       = 1'b1;
                        w_rdst_nxt = w_rdst;
                        w_op1      = w_rd_data1;
                        if (w_opc != OP_MOV) w_op2 = w_rd_data2;
                        case (w_opc)
                            OP_SUB:  w_mode = ALU_SUB;
                            OP_AND:  w_mode = ALU_AND;
                            OP_OR:   w_mode = ALU_OR;
                            default: w_mode = ALU_ADD;
                        endcase
                    end
                    OP_LDM, OP_IADD: begin
                        w_load      = 1'b1;
                        w_state_nxt = S_IMM;
                    end
                    default: w_illegal = 1'b1;
                endcase
            end
        end else if (instr_valid_i) begin
            w_vld       = 1'b1;
            w_wb        = 1'b1;
            w_rdst_nxt  = r_hold_rdst;
            w_state_nxt = S_DECODE;
            if (r_hold_opc == OP_LDM) begin
                w_op1 = instr_i;
            end else begin
                w_op1 = w_rd_data1;
                w_op2 = instr_i;
            end
        end
    end

    // FSM state and two-word holding registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_DECODE;
            r_hold_opc  <= '0;
            r_hold_rdst <= '0;
            r_hold_rs1  <= '0;
        end else if (flush_i) begin
            r_state     <= S_DECODE;
            r_hold_opc  <= '0;
            r_hold_rdst <= '0;
            r_hold_rs1  <= '0;
        end else if (!stall_i) begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_hold_opc  <= w_opc;
                r_hold_rdst <= w_rdst;
                r_hold_rs1  <= w_rs1;
            end
        end
    end

    // ID/EX boundary: stall holds, flush clears the control bits
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_op1_p1     <= '0;
            r_op2_p1     <= '0;
            r_mode_p1    <= '0;
            r_rdst_p1    <= '0;
            r_wb_p1      <= 1'b0;
            r_vld_p1     <= 1'b0;
            r_illegal_p1 <= 1'b0;
        end else if (flush_i) begin
            r_wb_p1      <= 1'b0;
            r_vld_p1     <= 1'b0;
            r_illegal_p1 <= 1'b0;
        end else if (stall_i) begin
            r_illegal_p1 <= 1'b0;
        end else begin
            r_op1_p1     <= w_op1;
            r_op2_p1     <= w_op2;
            r_mode_p1    <= w_mode;
            r_rdst_p1    <= w_rdst_nxt;
            r_wb_p1      <= w_wb;
            r_vld_p1     <= w_vld;
            r_illegal_p1 <= w_illegal;
        end
    end

    assign Op1        = r_op1_p1;
    assign Op2        = r_op2_p1;
    assign AlUmode    = r_mode_p1;
    assign rdst_o     = r_rdst_p1;
    assign wb_en_o    = r_wb_p1;
    assign valid_o    = r_vld_p1;
    assign illegal_o  = r_illegal_p1;
    assign imm_wait_o = (r_state == S_IMM);

endmodule

// File: tb/tb_decode_stage.sv
// Directed-vector bench for decode_stage with hand-computed expected values.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] instr_i;
    logic        instr_valid_i, stall_i, flush_i, wb_en_i;
    logic [2:0]  wb_addr_i;
    logic [15:0] wb_data_i;
    logic [15:0] Op1, Op2;
    logic [1:0]  AlUmode;
    logic [2:0]  rdst_o;
    logic        wb_en_o, valid_o, imm_wait_o, illegal_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk           (clk),
        .reset         (reset),
        .instr_i       (instr_i),
        .instr_valid_i (instr_valid_i),
        .stall_i       (stall_i),
        .flush_i       (flush_i),
        .wb_en_i       (wb_en_i),
        .wb_addr_i     (wb_addr_i),
        .wb_data_i     (wb_data_i),
        .Op1           (Op1),
        .Op2           (Op2),
        .AlUmode       (AlUmode),
        .rdst_o        (rdst_o),
        .wb_en_o       (wb_en_o),
        .valid_o       (valid_o),
        .imm_wait_o    (imm_wait_o),
        .illegal_o     (illegal_o)
    );

    task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        instr_valid_i = 1'b0; instr_i = 16'h0000;
        stall_i = 1'b0; flush_i = 1'b0; wb_en_i = 1'b0;
        wb_addr_i = 3'd0; wb_data_i = 16'h0000;
    endtask

    task automatic wb(input logic [2:0] a, input logic [15:0] d);
        idle();
        wb_en_i = 1'b1; wb_addr_i = a; wb_data_i = d;
        step();
        wb_en_i = 1'b0;
    endtask

    task automatic issue(input logic [15:0] w);
        instr_valid_i = 1'b1; instr_i = w;
        step();
        instr_valid_i = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".Op1"}, Op1, 16'h0);
        chk({tag, ".Op2"}, Op2, 16'h0);
        chk({tag, ".mode"}, {14'd0, AlUmode}, 16'h0);
        chk({tag, ".rdst"}, {13'd0, rdst_o}, 16'h0);
        chk({tag, ".ctl"}, {12'd0, wb_en_o, valid_o, imm_wait_o, illegal_o}, 16'h0);
    endtask

    initial begin
        logic [15:0] w;
        logic [2:0]  ri;
        idle();
        reset = 1'b0;
        #12;
        chk_all_zero("rst0");
        @(negedge clk);
        reset = 1'b1;
        step();

        // ADD R3,R1,R2 after write-back of R1/R2
        wb(3'd1, 16'h0005);
        wb(3'd2, 16'h0003);
        issue(16'h0B28);
        chk("add.Op1", Op1, 16'h0005);
        chk("add.Op2", Op2, 16'h0003);
        chk("add.mode", {14'd0, AlUmode}, 16'h0000);
        chk("add.rdst", {13'd0, rdst_o}, 16'h0003);
        chk("add.wb_vld", {14'd0, wb_en_o, valid_o}, 16'h0003);

        // SUB with same-cycle write-back of R1
        wb_en_i = 1'b1; wb_addr_i = 3'd1; wb_data_i = 16'h00AA;
        issue(16'h1428);
        wb_en_i = 1'b0;
        chk("byp.Op1", Op1, 16'h00AA);
        chk("byp.Op2", Op2, 16'h0003);
        chk("byp.mode", {14'd0, AlUmode}, 16'h0001);
        chk("byp.rdst", {13'd0, rdst_o}, 16'h0004);

        // IADD R6,R1,#0x0010
        issue(16'h3E20);
        chk("iadd.wait", {15'd0, imm_wait_o}, 16'h1);
        chk("iadd.bub", {15'd0, valid_o}, 16'h0);
        issue(16'h0010);
        chk("iadd.Op1", Op1, 16'h00AA);
        chk("iadd.Op2", Op2, 16'h0010);
        chk("iadd.rdst", {13'd0, rdst_o}, 16'h0006);
        chk("iadd.vld", {15'd0, valid_o}, 16'h1);

        // asynchronous reset mid-run clears registers and outputs
        #2;
        reset = 1'b0;
        #1;
        chk_all_zero("rst1");
        @(negedge clk);
        reset = 1'b1;
        step();
        for (int i = 0; i < 8; i++) begin
            ri = 3'(i);
            w = {5'b00101, 3'd7, ri, 5'd0};
            issue(w);
            chk($sformatf("mov%0d.Op1", i), Op1, 16'h0000);
            chk($sformatf("mov%0d.vld", i), {15'd0, valid_o}, 16'h1);
        end

        // LDM R5 with a gap before the immediate
        issue(16'h3500);
        chk("ldm.wait", {15'd0, imm_wait_o}, 16'h1);
        chk("ldm.bub", {15'd0, valid_o}, 16'h0);
        step();
        chk("ldm.gap_wait", {15'd0, imm_wait_o}, 16'h1);
        chk("ldm.gap_bub", {15'd0, valid_o}, 16'h0);
        issue(16'h1234);
        chk("ldm.Op1", Op1, 16'h1234);
        chk("ldm.Op2", Op2, 16'h0000);
        chk("ldm.rdst", {13'd0, rdst_o}, 16'h0005);
        chk("ldm.vld", {15'd0, valid_o}, 16'h1);
        chk("ldm.done", {15'd0, imm_wait_o}, 16'h0);

        // reset while waiting for the immediate
        issue(16'h3500);
        chk("ldm2.wait", {15'd0, imm_wait_o}, 16'h1);
        reset = 1'b0;
        #1;
        chk("rstimm.wait", {15'd0, imm_wait_o}, 16'h0);
        @(negedge clk);
        reset = 1'b1;
        step();
        wb(3'd1, 16'h0007);
        wb(3'd2, 16'h0009);
        issue(16'h0B28);
        chk("add2.Op1", Op1, 16'h0007);
        chk("add2.Op2", Op2, 16'h0009);
        chk("add2.vld", {15'd0, valid_o}, 16'h1);

        // stall holds ID/EX for three cycles despite a new word on instr_i
        stall_i = 1'b1; instr_valid_i = 1'b1; instr_i = 16'h1428;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("stall%0d.Op1", i), Op1, 16'h0007);
            chk($sformatf("stall%0d.mode", i), {14'd0, AlUmode}, 16'h0000);
            chk($sformatf("stall%0d.rdst", i), {13'd0, rdst_o}, 16'h0003);
            chk($sformatf("stall%0d.vld", i), {14'd0, wb_en_o, valid_o}, 16'h0003);
        end
        flush_i = 1'b1;
        step();
        chk("flush.wb_vld", {14'd0, wb_en_o, valid_o}, 16'h0000);
        idle();

        // illegal opcode pulses once; under stall it does not
        issue(16'hF800);
        chk("ill.pulse", {15'd0, illegal_o}, 16'h1);
        chk("ill.vld", {15'd0, valid_o}, 16'h0);
        step();
        chk("ill.once", {15'd0, illegal_o}, 16'h0);
        stall_i = 1'b1;
        issue(16'hF800);
        chk("ill.stall", {15'd0, illegal_o}, 16'h0);
        stall_i = 1'b0;
        step();
        chk("ill.after", {15'd0, illegal_o}, 16'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
